// File: rtl/key_conditioner_pkg.sv
// Shared types, default 50 MHz timing constants and key index names for the
// push-button conditioning path.
package key_conditioner_pkg;

    localparam int DEF_NUM_KEYS         = 16;
    localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
    localparam int DEF_REPEAT_DELAY_CYC = 25_000_000;
    localparam int DEF_REPEAT_RATE_CYC  = 5_000_000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } lane_state_e;

    typedef enum int {
        KEY_START    = 32'd0,
        KEY_RESTART  = 32'd1,
        KEY_MOVE     = 32'd2,
        KEY_B1_UP    = 32'd3,
        KEY_B1_DOWN  = 32'd4,
        KEY_B1_LEFT  = 32'd5,
        KEY_B1_RIGHT = 32'd6,
        KEY_B2_UP    = 32'd7,
        KEY_B2_DOWN  = 32'd8,
        KEY_B2_LEFT  = 32'd9,
        KEY_B2_RIGHT = 32'd10
    } key_idx_e;

    // Counter width that still works for degenerate counts of 0 or 1.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/key_conditioner_lane.sv
// One key lane: 2-flop sync, polarity fix, debounce FSM and auto-repeat timer.
module key_conditioner_lane
    import key_conditioner_pkg::*;
#(
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int RMAX   = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int DCNT_W = cnt_width(DEBOUNCE_CYC);
    localparam int RCNT_W = cnt_width(RMAX);
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RCNT_W-1:0] RDELAY_LAST = RCNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RCNT_W-1:0] RRATE_LAST  = RCNT_W'(REPEAT_RATE_CYC - 1);

    logic              sync1_q, sync_q;
    lane_state_e       state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              first_q, first_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    logic              db_last_s;
    logic              rpt_last_s;

    assign db_last_s  = (dcnt_q == DCNT_LAST);
    assign rpt_last_s = first_q ? (rcnt_q == RDELAY_LAST) : (rcnt_q == RRATE_LAST);

    // Debounce FSM plus repeat timer; idle/held share logic with their DB states.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        first_d   = first_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DB_PRESS: begin
                if (!sync_q) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (db_last_s) begin
                    state_d = ST_HELD;
                    dcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_DB_PRESS;
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end
            ST_HELD, ST_DB_RELEASE: begin
                if (sync_q) begin
                    state_d = ST_HELD;
                    dcnt_d  = '0;
                end else if (db_last_s) begin
                    state_d   = ST_IDLE;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                end else begin
                    state_d = ST_DB_RELEASE;
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
            end
        endcase

        // The timer only advances in HELD, so it freezes while a release is being qualified.
        if (press_d || !level_q || !repeat_en_i) begin
            rcnt_d  = '0;
            first_d = 1'b1;
        end else if (state_q == ST_HELD) begin
            if (rpt_last_s) begin
                rcnt_d   = '0;
                first_d  = 1'b0;
                repeat_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RCNT_W'(1);
            end
        end else begin
            rcnt_d  = rcnt_q;
            first_d = first_q;
        end
    end

    assign level_d = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);

    // Lane state and registered outputs; sync flops reset to the released value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            first_q   <= 1'b1;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= pin_i ^ ACTIVE_LOW;
            sync_q    <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            first_q   <= first_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner top: one independent lane per key, buses sliced here.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS         = DEF_NUM_KEYS,
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_conditioner_lane #(
            .ACTIVE_LOW       (ACTIVE_LOW),
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .pin_i       (key_in[i]),
            .repeat_en_i (repeat_en[i]),
            .level_o     (key_level[i]),
            .press_o     (key_press[i]),
            .release_o   (key_release[i]),
            .repeat_o    (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] repeat_en;
    logic [3:0] key_level, key_press, key_release, key_repeat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] e_lvl, e_prs, e_rel, e_rpt;

    key_conditioner #(
        .NUM_KEYS         (4),
        .ACTIVE_LOW       (1'b1),
        .DEBOUNCE_CYC     (8),
        .REPEAT_DELAY_CYC (20),
        .REPEAT_RATE_CYC  (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        key_in = 4'hF;
        repeat (14) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_in = 4'hF; repeat_en = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
            $display("FAIL reset_outputs got=%h exp=%h", {key_level, key_press, key_release, key_repeat}, 16'h0000);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, 16'h0000);
            else n_pass++;
        end
    endtask

    task automatic test_press();
        key_in[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            e_lvl = (i >= 10) ? 4'b0001 : 4'b0000;
            e_prs = (i == 10) ? 4'b0001 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, 4'b0000, 4'b0000})
                $display("FAIL press cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, 8'h00});
            else n_pass++;
        end
        key_in[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            e_lvl = (i < 10) ? 4'b0001 : 4'b0000;
            e_rel = (i == 10) ? 4'b0001 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, 4'b0000, e_rel, 4'b0000})
                $display("FAIL release cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, 4'b0000, e_rel, 4'b0000});
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int plen [3] = '{3, 5, 7};
        int k = 0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < plen[p] + 2; j++) begin
                key_in[1] = (j < plen[p]) ? 1'b0 : 1'b1;
                step();
                k++;
                n_checks++;
                if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
                    $display("FAIL glitch cyc=%0d got=%h exp=%h", k, {key_level, key_press, key_release, key_repeat}, 16'h0000);
                else n_pass++;
            end
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
                $display("FAIL glitch_tail cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, 16'h0000);
            else n_pass++;
        end
        // An exactly 8-cycle low pulse is just long enough to be accepted.
        key_in[1] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 8) key_in[1] = 1'b1;
            e_lvl = (i >= 10 && i <= 17) ? 4'b0010 : 4'b0000;
            e_prs = (i == 10) ? 4'b0010 : 4'b0000;
            e_rel = (i == 18) ? 4'b0010 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, e_rel, 4'b0000})
                $display("FAIL glitch_min_pulse cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, e_rel, 4'b0000});
            else n_pass++;
        end
    endtask

    task automatic test_repeat();
        repeat_en = 4'b0100;
        key_in[2] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            step();
            e_lvl = (i >= 10 && i <= 73) ? 4'b0100 : 4'b0000;
            e_prs = (i == 10) ? 4'b0100 : 4'b0000;
            e_rel = (i == 74) ? 4'b0100 : 4'b0000;
            e_rpt = (i >= 30 && i <= 65 && (i % 5) == 0) ? 4'b0100 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, e_rel, e_rpt})
                $display("FAIL repeat cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, e_rel, e_rpt});
            else n_pass++;
            if (i == 64) key_in[2] = 1'b1;
        end
        repeat_en = 4'b0000;
    endtask

    task automatic test_back_to_back();
        key_in = 4'b0110;
        for (int i = 1; i <= 14; i++) begin
            step();
            e_lvl = (i >= 10) ? 4'b1001 : 4'b0000;
            e_prs = (i == 10) ? 4'b1001 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, 4'b0000, 4'b0000})
                $display("FAIL multi_press cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, 8'h00});
            else n_pass++;
        end
        key_in = 4'hF;
        for (int i = 1; i <= 12; i++) begin
            step();
            e_lvl = (i < 10) ? 4'b1001 : 4'b0000;
            e_rel = (i == 10) ? 4'b1001 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, 4'b0000, e_rel, 4'b0000})
                $display("FAIL multi_release cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, 4'b0000, e_rel, 4'b0000});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        key_in[0] = 1'b0;
        repeat (5) step();
        for (int pass = 0; pass < 2; pass++) begin
            #2;
            rst_n = 1'b0;
            #1;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
                $display("FAIL reset_mid_async pass=%0d got=%h exp=%h", pass, {key_level, key_press, key_release, key_repeat}, 16'h0000);
            else n_pass++;
            repeat (2) step();
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== 16'h0000)
                $display("FAIL reset_mid_hold pass=%0d got=%h exp=%h", pass, {key_level, key_press, key_release, key_repeat}, 16'h0000);
            else n_pass++;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 1; i <= 14; i++) begin
                step();
                e_lvl = (i >= 10) ? 4'b0001 : 4'b0000;
                e_prs = (i == 10) ? 4'b0001 : 4'b0000;
                n_checks++;
                if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, 4'b0000, 4'b0000})
                    $display("FAIL reset_mid_repress pass=%0d cyc=%0d got=%h exp=%h", pass, i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, 8'h00});
                else n_pass++;
            end
        end
        idle_wait();
    endtask

    task automatic test_repeat_en_drop();
        repeat_en = 4'b0100;
        key_in[2] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            step();
            e_lvl = (i >= 10) ? 4'b0100 : 4'b0000;
            e_prs = (i == 10) ? 4'b0100 : 4'b0000;
            e_rpt = (i == 30 || (i >= 60 && (i % 5) == 0)) ? 4'b0100 : 4'b0000;
            n_checks++;
            if ({key_level, key_press, key_release, key_repeat} !== {e_lvl, e_prs, 4'b0000, e_rpt})
                $display("FAIL repeat_en_drop cyc=%0d got=%h exp=%h", i, {key_level, key_press, key_release, key_repeat}, {e_lvl, e_prs, 4'b0000, e_rpt});
            else n_pass++;
            if (i == 32) repeat_en = 4'b0000;
            if (i == 40) repeat_en = 4'b0100;
        end
        repeat_en = 4'b0000;
        idle_wait();
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        idle_wait();
        test_back_to_back();
        test_reset_mid();
        test_repeat_en_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
